// File: rtl/trace_uart_if.sv
// Trace word bus from the CPU trace port into the trace UART.
// master: drives one 36-bit word per cycle with trace_valid high.
// slave: samples trace_valid/trace_data on every clock edge (no ready, drops when full).
interface trace_uart_if;
  logic        trace_valid;
  logic [35:0] trace_data;

  modport master (output trace_valid, output trace_data);
  modport slave  (input  trace_valid, input  trace_data);
endinterface

// File: rtl/trace_uart.sv
// Buffers trace words in a DEPTH-entry FIFO and prints each as 9 hex digits + CR LF on an 8N1 UART.
// Latency: a word written into an empty FIFO is popped on the next edge and its start bit begins there.
// Backpressure: none upstream; words arriving while full (and no pop that edge) are dropped and counted.
// Ports: clk, resn (async active-low), trc (trace_valid/trace_data), serial_out (idle high),
//        busy (FIFO non-empty or formatter active), overflow (sticky), drop_count (saturating).
module trace_uart #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic               clk,
  input  logic               resn,
  trace_uart_if.slave        trc,
  output logic               serial_out,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int AW      = $clog2(DEPTH);
  localparam int DIVW    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BIT_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO
  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_pop, fifo_push, fifo_full, drop;

  // Status
  logic       busy_q, busy_d, overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;

  // Formatter
  state_t          state_q;
  logic [35:0]     shift_q;
  logic [3:0]      char_idx_q;
  logic [2:0]      bit_idx_q;
  logic [DIVW-1:0] div_q;
  logic            serial_q;
  logic [7:0]      char_byte;
  logic            bit_end, fmt_done, fmt_idle_next;

  always_comb begin
    fifo_full = (count_q == FULL_CNT);
    // Pop decision uses pre-edge occupancy, so a full FIFO can accept a write on the pop edge.
    fifo_pop  = (state_q == S_IDLE) && (count_q != '0);
    fifo_push = trc.trace_valid && (!fifo_full || fifo_pop);
    drop      = trc.trace_valid && !fifo_push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (fifo_push && !fifo_pop)      count_d = count_q + (AW+1)'(1);
    else if (fifo_pop && !fifo_push) count_d = count_q - (AW+1)'(1);

    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

    bit_end       = (div_q == DIV_LAST);
    fmt_done      = (state_q == S_STOP) && bit_end && (char_idx_q == 4'd10);
    fmt_idle_next = ((state_q == S_IDLE) && !fifo_pop) || fmt_done;
    busy_d        = (count_d != '0) || !fmt_idle_next;

    // Current character: hex digit from the top nibble of the shifter, then CR, LF.
    if (char_idx_q == 4'd9)       char_byte = 8'h0D;
    else if (char_idx_q == 4'd10) char_byte = 8'h0A;
    else if (shift_q[35:32] < 4'd10) char_byte = 8'h30 + {4'h0, shift_q[35:32]};
    else                             char_byte = 8'h37 + {4'h0, shift_q[35:32]};
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= trc.trace_data;
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Formatter FSM; serial_q is set on the edge that enters each bit so the pin is glitch-free.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      char_idx_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      div_q      <= '0;
      serial_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            char_idx_q <= 4'd0;
            div_q      <= '0;
            serial_q   <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_q     <= '0;
            bit_idx_q <= 3'd0;
            serial_q  <= char_byte[0];
            state_q   <= S_DATA;
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= char_byte[bit_idx_q + 3'd1];
            end
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            div_q <= '0;
            if (char_idx_q == 4'd10) begin
              state_q <= S_IDLE;
            end else begin
              // Shifting past the last digit is harmless: CR/LF ignore the shifter.
              char_idx_q <= char_idx_q + 4'd1;
              shift_q    <= {shift_q[31:0], 4'h0};
              serial_q   <= 1'b0;
              state_q    <= S_START;
            end
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_trace_uart.sv
// Randomised/directed bench for trace_uart against a queue-and-timeline reference model.
module tb_trace_uart;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int BD     = CLK_HZ / BAUD;
  localparam int LINE   = 110 * BD;

  logic       clk = 1'b0;
  logic       resn;
  logic       serial_out, busy, overflow;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  trace_uart_if trc();

  trace_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .resn(resn), .trc(trc), .serial_out(serial_out),
    .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending words, and time since the current line started (-1 = idle).
  logic [35:0] mq[$];
  logic [35:0] cur_w;
  int          fmt_t;
  int          m_drops;
  bit          m_ovf;
  logic [7:0]  exp_bytes[$];

  // Serial decoder state.
  logic [7:0]  rx_bytes[$];
  bit          rx_active;
  int          rx_ph;
  logic [7:0]  rx_byte;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [35:0] w, input int idx);
    logic [3:0] nib;
    if (idx == 9)  return 8'h0D;
    if (idx == 10) return 8'h0A;
    nib = 4'((w >> (4 * (8 - idx))) & 36'hF);
    if (nib < 4'd10) return 8'h30 + 8'(nib);
    return 8'h41 + 8'(nib) - 8'd10;
  endfunction

  function automatic logic exp_serial();
    int frame, b;
    logic [7:0] ch;
    if (fmt_t < 0) return 1'b1;
    frame = fmt_t / (10 * BD);
    b     = (fmt_t % (10 * BD)) / BD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    ch = exp_char(cur_w, frame);
    return ch[b-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_bytes.delete();
    rx_bytes.delete();
    fmt_t     = -1;
    m_drops   = 0;
    m_ovf     = 1'b0;
    rx_active = 1'b0;
    rx_ph     = 0;
  endtask

  task automatic model_edge(input bit v, input logic [35:0] d);
    bit pop, full;
    pop  = (fmt_t < 0) && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    if (pop) begin
      cur_w = mq.pop_front();
      fmt_t = 0;
      for (int i = 0; i < 11; i++) exp_bytes.push_back(exp_char(cur_w, i));
    end else if (fmt_t >= 0) begin
      fmt_t++;
      if (fmt_t == LINE) fmt_t = -1;
    end
    if (v) begin
      if (!full || pop) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic rx_sample();
    int k;
    if (!rx_active) begin
      if (serial_out == 1'b0) begin
        rx_active = 1'b1;
        rx_ph     = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph % BD == BD / 2) begin
        k = rx_ph / BD;
        if (k >= 1 && k <= 8) rx_byte[k-1] = serial_out;
        if (k == 9) begin
          chk("rx_stop_bit", serial_out, 1'b1);
          rx_bytes.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  endtask

  // Enter at a negedge: drive inputs, take one edge, then compare on the following negedge.
  task automatic cycle(input bit v, input logic [35:0] d);
    trc.trace_valid = v;
    trc.trace_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    chk("serial_out", serial_out, exp_serial());
    chk("busy", busy, (mq.size() > 0) || (fmt_t >= 0));
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    rx_sample();
  endtask

  task automatic do_reset(input int n);
    resn = 1'b0;
    trc.trace_valid = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
    resn = 1'b1;
  endtask

  task automatic drain();
    int b = 0;
    while (((mq.size() > 0) || (fmt_t >= 0)) && b < 20000) begin
      cycle(1'b0, '0);
      b++;
    end
    chk("drain_bound", b < 20000, 1'b1);
    repeat (3) cycle(1'b0, '0);
  endtask

  task automatic cmp_bytes(input string tag);
    int n;
    chk({tag, "_nbytes"}, rx_bytes.size(), exp_bytes.size());
    n = (rx_bytes.size() < exp_bytes.size()) ? rx_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) chk(tag, rx_bytes[i], exp_bytes[i]);
    rx_bytes.delete();
    exp_bytes.delete();
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom_range(0, 15)), 32'($urandom())};
  endfunction

  initial begin
    logic [7:0] lit [11];
    int b;
    lit = '{8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    trc.trace_data = '0;

    // 1: reset values, then quiet line.
    do_reset(5);
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_count", drop_count, 8'd0);
    repeat (200) cycle(1'b0, '0);

    // 2: single word, decoded against literal ASCII.
    cycle(1'b1, 36'h9ABCD1234);
    chk("t2_busy_after_e0", busy, 1'b1);
    cycle(1'b0, '0);
    chk("t2_start_bit", serial_out, 1'b0);
    drain();
    chk("t2_nbytes", rx_bytes.size(), 11);
    for (int i = 0; i < 11; i++)
      chk("t2_ascii", (i < rx_bytes.size()) ? rx_bytes[i] : 8'hXX, lit[i]);
    cmp_bytes("t2_line");

    // 3: hex extremes back-to-back.
    cycle(1'b1, 36'h000000000);
    cycle(1'b1, 36'hFFFFFFFFF);
    drain();
    cmp_bytes("t3_line");

    // 4: overflow on the sixth word, then full + pop + write on one edge.
    for (int i = 1; i <= 6; i++) cycle(1'b1, 36'(i));
    chk("t4_drop_count", drop_count, 8'd1);
    chk("t4_overflow", overflow, 1'b1);
    b = 0;
    while (fmt_t >= 0 && b < 5000) begin cycle(1'b0, '0); b++; end
    chk("t4_wait_idle", b < 5000, 1'b1);
    chk("t4_fifo_full", mq.size(), DEPTH);
    cycle(1'b1, 36'h777777777);
    chk("t4_fpw_no_drop", drop_count, 8'd1);
    drain();
    cmp_bytes("t4_line");

    // Random traffic, sparse enough to drain but dense enough to overflow occasionally.
    for (int i = 0; i < 4000; i++) cycle(($urandom_range(0, 399) == 0), rand36());
    drain();
    cmp_bytes("rand_line");

    // 5: saturation.
    for (int i = 0; i < 305; i++) cycle(1'b1, rand36());
    chk("t5_drop_sat", drop_count, 8'd255);
    chk("t5_overflow", overflow, 1'b1);
    repeat (20) cycle(1'b1, rand36());
    chk("t5_drop_stays", drop_count, 8'd255);
    drain();
    cmp_bytes("t5_line");

    // 6: asynchronous reset in the middle of a data bit of char 3.
    cycle(1'b1, 36'h123456789);
    cycle(1'b1, 36'hABCDEF012);
    b = 0;
    while (fmt_t != (3 * 10 * BD + 4 * BD + BD / 2) && b < 5000) begin cycle(1'b0, '0); b++; end
    chk("t6_reach_char3", b < 5000, 1'b1);
    #2;
    resn = 1'b0;
    #1;
    chk("t6_async_serial", serial_out, 1'b1);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_overflow", overflow, 1'b0);
    chk("t6_async_drop", drop_count, 8'd0);
    model_reset();
    repeat (3) @(negedge clk);
    resn = 1'b1;
    repeat (300) cycle(1'b0, '0);
    chk("t6_no_chars", rx_bytes.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
